mod12_seq_checker: RTL and testbench

Receive-side monitor for a free-running mod-12 count stream of values 0..11 on a 4-bit bus. It samples the stream and locks onto the sequence after a programmable number of consecutive legal increments. It then flags skips, stalls and out-of-range values, and keeps wrap and error statistics. It sits at the consumer end of any mod-12 counter output, in silicon or as a bench-reusable checker.

---
 rtl/mod12_seq_checker.sv | 161 ++++++++++++++++
 tb/tb_mod12_seq_checker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod12_seq_checker.sv
// Receive-side monitor for a mod-12 count stream: locks after LOCK_LEN good
// transitions, then reports skips, stalls and out-of-range values with statistics.
module mod12_seq_checker #(
  parameter int unsigned LOCK_LEN = 4,
  parameter int unsigned WRAP_W   = 8,
  parameter int unsigned ERR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [3:0]        count_in,
  input  logic              src_reset,
  input  logic              clear_err,
  output logic              locked,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              fault_sticky,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int unsigned VAL_W  = 4;
  localparam int unsigned SYNC_W = 4;
  localparam logic [VAL_W-1:0] MAX_VAL = VAL_W'(11);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_SKIP  = 2'b01;
  localparam logic [1:0] CODE_STALL = 2'b10;
  localparam logic [1:0] CODE_RANGE = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t              r_state,  w_state_nxt;
  logic [VAL_W-1:0]    r_prev,   w_prev_nxt;
  logic [SYNC_W-1:0]   r_sync,   w_sync_nxt;
  logic                r_locked, w_locked_nxt;
  logic                r_err,    w_err_det;
  logic [1:0]          r_code,   w_code_nxt;
  logic                r_sticky, w_sticky_nxt;
  logic [WRAP_W-1:0]   r_wrap,   w_wrap_nxt;
  logic [ERR_W-1:0]    r_ecnt,   w_ecnt_nxt;
  logic [1:0]          w_code_det;
  logic [VAL_W-1:0]    w_expected;
  logic [SYNC_W-1:0]   w_sync_inc;
  logic                w_in_range;

  assign w_expected = (r_prev == MAX_VAL) ? '0 : r_prev + VAL_W'(1);
  assign w_sync_inc = r_sync + SYNC_W'(1);
  assign w_in_range = (count_in <= MAX_VAL);

  // Next-state, sequence tracking and error detection
  always_comb begin
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev;
    w_sync_nxt   = r_sync;
    w_locked_nxt = r_locked;
    w_wrap_nxt   = r_wrap;
    w_err_det    = 1'b0;
    w_code_det   = CODE_NONE;

    if (src_reset) begin
      w_state_nxt  = IDLE;
      w_sync_nxt   = '0;
      w_locked_nxt = 1'b0;
    end else if (en) begin
      if (!w_in_range) begin
        w_err_det    = 1'b1;
        w_code_det   = CODE_RANGE;
        w_state_nxt  = IDLE;
        w_sync_nxt   = '0;
        w_locked_nxt = 1'b0;
      end else begin
        w_prev_nxt = count_in;
        unique case (r_state)
          IDLE: begin
            w_state_nxt = SYNC;
            w_sync_nxt  = '0;
          end
          SYNC: begin
            if (count_in == w_expected) begin
              w_sync_nxt = w_sync_inc;
              if (w_sync_inc == SYNC_W'(LOCK_LEN)) begin
                w_state_nxt  = LOCKED;
                w_locked_nxt = 1'b1;
              end
            end else begin
              w_sync_nxt = '0;
            end
          end
          LOCKED: begin
            if (count_in == w_expected) begin
              if (r_prev == MAX_VAL) w_wrap_nxt = r_wrap + WRAP_W'(1);
            end else begin
              w_err_det    = 1'b1;
              w_code_det   = (count_in == r_prev) ? CODE_STALL : CODE_SKIP;
              w_state_nxt  = SYNC;
              w_sync_nxt   = '0;
              w_locked_nxt = 1'b0;
            end
          end
          default: w_state_nxt = IDLE;
        endcase
      end
    end
  end

  // Error statistics; a new error overrides a simultaneous clear
  always_comb begin
    w_code_nxt   = r_code;
    w_sticky_nxt = r_sticky;
    w_ecnt_nxt   = r_ecnt;
    if (clear_err) begin
      w_code_nxt   = CODE_NONE;
      w_sticky_nxt = 1'b0;
      w_ecnt_nxt   = '0;
    end
    if (w_err_det) begin
      w_code_nxt   = w_code_det;
      w_sticky_nxt = 1'b1;
      if (clear_err)   w_ecnt_nxt = ERR_W'(1);
      else if (&r_ecnt) w_ecnt_nxt = r_ecnt;
      else             w_ecnt_nxt = r_ecnt + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_prev   <= '0;
      r_sync   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_code   <= CODE_NONE;
      r_sticky <= 1'b0;
      r_wrap   <= '0;
      r_ecnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= w_prev_nxt;
      r_sync   <= w_sync_nxt;
      r_locked <= w_locked_nxt;
      r_err    <= w_err_det;
      r_code   <= w_code_nxt;
      r_sticky <= w_sticky_nxt;
      r_wrap   <= w_wrap_nxt;
      r_ecnt   <= w_ecnt_nxt;
    end
  end

  assign locked       = r_locked;
  assign err          = r_err;
  assign err_code     = r_code;
  assign fault_sticky = r_sticky;
  assign wrap_cnt     = r_wrap;
  assign err_cnt      = r_ecnt;

endmodule

// File: tb/tb_mod12_seq_checker.sv
// Scoreboard bench for mod12_seq_checker: directed scenarios plus randomized
// count streams checked against an arithmetic reference model.
module tb_mod12_seq_checker;

  localparam int unsigned LOCK_LEN = 4;
  localparam int unsigned WRAP_W   = 8;
  localparam int unsigned ERR_W    = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic [3:0]        count_in = '0;
  logic              src_reset = 1'b0;
  logic              clear_err = 1'b0;
  logic              locked;
  logic              err;
  logic [1:0]        err_code;
  logic              fault_sticky;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [ERR_W-1:0]  err_cnt;

  mod12_seq_checker #(.LOCK_LEN(LOCK_LEN), .WRAP_W(WRAP_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .en(en), .count_in(count_in),
    .src_reset(src_reset), .clear_err(clear_err), .locked(locked), .err(err),
    .err_code(err_code), .fault_sticky(fault_sticky), .wrap_cnt(wrap_cnt),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int locked;
    int err;
    int code;
    int sticky;
    int wrap;
    int ecnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: mode 0 = waiting, 1 = counting good steps, 2 = locked
  int   m_mode, m_prev, m_good;
  exp_t m;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_good = 0;
    m = '{0, 0, 0, 0, 0, 0};
  endtask

  task automatic model_step(input bit e, input int c, input bit s, input bit clr);
    int code;
    int nxt;
    code  = 0;
    nxt   = (m_prev + 1) % 12;
    m.err = 0;
    if (s) begin
      m_mode = 0; m_good = 0; m.locked = 0;
    end else if (e) begin
      if (c > 11) begin
        code = 3; m_mode = 0; m_good = 0; m.locked = 0;
      end else begin
        if (m_mode == 0) begin
          m_mode = 1; m_good = 0;
        end else if (m_mode == 1) begin
          if (c == nxt) begin
            m_good++;
            if (m_good == LOCK_LEN) begin m_mode = 2; m.locked = 1; end
          end else m_good = 0;
        end else begin
          if (c == nxt) begin
            if (c == 0) m.wrap = (m.wrap + 1) % (1 << WRAP_W);
          end else begin
            code = (c == m_prev) ? 2 : 1;
            m_mode = 1; m_good = 0; m.locked = 0;
          end
        end
        m_prev = c;
      end
    end
    if (clr) begin m.code = 0; m.ecnt = 0; m.sticky = 0; end
    if (code != 0) begin
      m.err = 1; m.code = code; m.sticky = 1;
      if (m.ecnt < (1 << ERR_W) - 1) m.ecnt++;
    end
  endtask

  // Drive one sampling edge; expected response goes to the scoreboard
  task automatic step(input bit e, input int c, input bit s = 1'b0, input bit clr = 1'b0);
    en = e; count_in = 4'(c); src_reset = s; clear_err = clr;
    @(posedge clk);
    model_step(e, c, s, clr);
    sb_q.push_back(m);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_locked", 32'(locked), 0);
    chk("async_err", 32'(err), 0);
    chk("async_code", 32'(err_code), 0);
    chk("async_sticky", 32'(fault_sticky), 0);
    chk("async_wrap", 32'(wrap_cnt), 0);
    chk("async_ecnt", 32'(err_cnt), 0);
    model_reset();
    en = 1'b0; src_reset = 1'b0; clear_err = 1'b0;
    @(posedge clk);
    sb_q.push_back(m);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents a registered response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("locked", 32'(locked), 32'(e.locked));
        chk("err", 32'(err), 32'(e.err));
        chk("err_code", 32'(err_code), 32'(e.code));
        chk("fault_sticky", 32'(fault_sticky), 32'(e.sticky));
        chk("wrap_cnt", 32'(wrap_cnt), 32'(e.wrap));
        chk("err_cnt", 32'(err_cnt), 32'(e.ecnt));
      end
    end
  end

  initial begin
    int  gen, r, v;
    bit  e, s, c;
    model_reset();
    do_reset();

    // Lock and wrap
    for (int i = 0; i < 14; i++) begin
      step(1, i % 12);
      if (i == 3) chk("t1_not_yet", 32'(locked), 0);
      if (i == 4) chk("t1_lock", 32'(locked), 1);
      if (i == 12) chk("t1_wrap", 32'(wrap_cnt), 1);
    end
    chk("t1_code", 32'(err_code), 0);

    // Skip then relock on 11
    for (int i = 2; i <= 5; i++) step(1, i);
    step(1, 7);
    chk("t2_err", 32'(err), 1);
    chk("t2_code", 32'(err_code), 1);
    chk("t2_ecnt", 32'(err_cnt), 1);
    chk("t2_locked", 32'(locked), 0);
    step(1, 8); step(1, 9); step(1, 10);
    chk("t2_err_pulse", 32'(err), 0);
    step(1, 11);
    chk("t2_relock", 32'(locked), 1);

    // Stall, then a repeated value while en is low
    step(1, 0); step(1, 1); step(1, 2); step(1, 3); step(1, 3);
    chk("t3_code", 32'(err_code), 2);
    chk("t3_locked", 32'(locked), 0);
    for (int i = 4; i <= 8; i++) step(1, i);
    step(0, 8);
    chk("t3_en_low_locked", 32'(locked), 1);
    chk("t3_en_low_err", 32'(err), 0);
    step(1, 9);

    // Range errors in LOCKED and IDLE
    step(1, 13);
    chk("t4_code", 32'(err_code), 3);
    chk("t4_locked", 32'(locked), 0);
    step(1, 2);
    chk("t4_no_err", 32'(err), 0);
    step(1, 14);
    step(1, 14);
    chk("t4_ecnt", 32'(err_cnt), 5);
    step(1, 3, 0, 1);
    chk("t4_clear", 32'(err_cnt), 0);
    for (int i = 4; i <= 7; i++) step(1, i);

    // Source reset then fresh start, and the same stream without it
    step(1, 8, 1, 0);
    chk("t5_unlock", 32'(locked), 0);
    chk("t5_no_err", 32'(err), 0);
    for (int i = 0; i <= 4; i++) step(1, i);
    chk("t5_relock", 32'(locked), 1);
    step(1, 5); step(1, 6); step(1, 7); step(1, 0);
    chk("t5_skip", 32'(err_code), 1);

    // Clear on the same edge as a skip
    for (int i = 1; i <= 4; i++) step(1, i);
    step(1, 6, 0, 1);
    chk("t6_ecnt", 32'(err_cnt), 1);
    chk("t6_code", 32'(err_code), 1);
    chk("t6_sticky", 32'(fault_sticky), 1);
    for (int i = 7; i <= 10; i++) step(1, i);
    step(1, 10);
    step(1, 11); step(1, 0); step(1, 1); step(1, 2);
    step(1, 4);
    for (int i = 5; i <= 8; i++) step(1, i);
    chk("t6_pre_locked", 32'(locked), 1);
    chk("t6_pre_ecnt", 32'(err_cnt), 3);
    do_reset();

    // Randomized streams with occasional faults
    gen = 0;
    for (int n = 0; n < 3000; n++) begin
      e = ($urandom_range(0, 99) < 85);
      s = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 5);
      r = $urandom_range(0, 99);
      if (r < 85)      v = gen;
      else if (r < 90) v = (gen + 11) % 12;
      else if (r < 96) v = $urandom_range(0, 11);
      else             v = $urandom_range(12, 15);
      step(e, v, s, c);
      if (s) gen = 0;
      else if (e && r < 85) gen = (gen + 1) % 12;
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
